dht11_reader: RTL and testbench

//  Single-wire DHT11 protocol controller that sits directly upstream of the tristate pin buffer.
//  It drives dir/data_out to issue the start pulse, then releases the line.
//  It samples data_in to decode the 40-bit sensor frame (hum_int, hum_dec, tmp_int, tmp_dec, checksum).

---
 rtl/dht11_reader.sv | 187 ++++++++++++++++++
 tb/tb_dht11_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// dht11_reader: single-wire DHT11 host. It issues the start pulse, decodes the 40-bit sensor
// frame, and presents the four data bytes together with a one-cycle done or error strobe.
module dht11_reader #(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 100,
  parameter int unsigned BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       dir,
  output logic       data_out,
  input  logic       data_in,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec
);

  localparam int unsigned CYC_PER_US = (CLK_FREQ_HZ >= 1_000_000) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned PW         = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam int unsigned US_MAX_A   = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int unsigned US_MAX     = (US_MAX_A > BIT_THRESH_US) ? US_MAX_A : BIT_THRESH_US;
  localparam int unsigned UW         = $clog2(US_MAX + 2);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  state_t        state, state_d;

  logic [2:0]    sync;
  logic          rise, fall;
  logic [PW-1:0] presc;
  logic          tick;
  logic [UW-1:0] us_cnt;
  logic [UW:0]   elapsed;
  logic          timeout;
  logic          bit_val;
  logic [5:0]    bit_cnt;
  logic [39:0]   shreg;
  logic [7:0]    sum;

  logic          done_d, error_d, load_d;
  logic          shift_en, bit_clr, bit_inc;

  // sync[1] is the synchronised pin, sync[2] its previous value for edge detection
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];

  assign busy     = (state != IDLE);
  assign dir      = (state == START_LOW);
  assign data_out = 1'b0;

  assign tick    = busy && (presc == PW'(CYC_PER_US - 1));
  assign timeout = tick && (us_cnt == UW'(TIMEOUT_US - 1));

  // Width measured including the tick of the detecting cycle; the synchroniser delays
  // both edges equally, so this equals the high time seen on the pin.
  assign elapsed = {1'b0, us_cnt} + {{UW{1'b0}}, tick};
  assign bit_val = (elapsed > (UW + 1)'(BIT_THRESH_US));

  assign sum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    error_d  = 1'b0;
    load_d   = 1'b0;
    shift_en = 1'b0;
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = START_LOW;
      end
      START_LOW: begin
        if (tick && (us_cnt == UW'(START_LOW_US - 1))) state_d = RELEASE;
      end
      RELEASE: begin
        if (fall) state_d = RESP_LOW;
        else if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      RESP_LOW: begin
        if (rise) state_d = RESP_HIGH;
        else if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      RESP_HIGH: begin
        if (fall) begin
          state_d = BIT_LOW;
          bit_clr = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      BIT_LOW: begin
        if (rise) state_d = BIT_HIGH;
        else if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 6'd39) state_d = CHECK;
          else begin
            bit_inc = 1'b1;
            state_d = BIT_LOW;
          end
        end else if (timeout) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (sum == shreg[7:0]) begin
          done_d = 1'b1;
          load_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sync    <= '1;
      presc   <= '0;
      us_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      hum_int <= '0;
      hum_dec <= '0;
      tmp_int <= '0;
      tmp_dec <= '0;
    end else begin
      state <= state_d;
      sync  <= {sync[1:0], data_in};
      done  <= done_d;
      error <= error_d;

      if (!busy || tick) presc <= '0;
      else               presc <= presc + 1'b1;

      if (state_d != state) us_cnt <= '0;
      else if (tick)        us_cnt <= us_cnt + 1'b1;

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shreg <= {shreg[38:0], bit_val};

      if (load_d) begin
        hum_int <= shreg[39:32];
        hum_dec <= shreg[31:24];
        tmp_int <= shreg[23:16];
        tmp_dec <= shreg[15:8];
      end
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// tb_dht11_reader: directed bench with a behavioural DHT11 sensor driving the shared pin.
module tb_dht11_reader;

  localparam int START_LOW_US = 20;

  logic       clk;
  logic       reset;
  logic       start;
  logic       dir;
  logic       data_out;
  logic       data_in;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
  logic       line;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int done_cyc = 0;
  int err_cyc  = 0;
  int fall_cyc = 0;
  logic done_q = 1'b0;
  logic error_q = 1'b0;
  int hi_w[40];

  dht11_reader #(
    .CLK_FREQ_HZ  (1_000_000),
    .START_LOW_US (START_LOW_US),
    .TIMEOUT_US   (100),
    .BIT_THRESH_US(40)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dir     (dir),
    .data_out(data_out),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .hum_int (hum_int),
    .hum_dec (hum_dec),
    .tmp_int (tmp_int),
    .tmp_dec (tmp_dec)
  );

  // pin: host drives when dir=1, otherwise the sensor (pull-up idle high)
  assign data_in = dir ? data_out : line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (error === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
    if ((done === 1'b1 && done_q === 1'b1) || (error === 1'b1 && error_q === 1'b1))
      long_cnt <= long_cnt + 1;
    done_q  <= done;
    error_q <= error;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic set_widths(input logic [39:0] frame);
    for (int b = 0; b < 40; b++) hi_w[b] = frame[39 - b] ? 70 : 26;
  endtask

  task automatic run_frame(input bit respond, input int abort_bit, input int restart_bit);
    int n;
    int busy_low;
    bit aborted;
    aborted  = 1'b0;
    busy_low = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_dir", int'(dir), 1);
    check("start_data_out", int'(data_out), 0);
    n = 0;
    while (dir && n < 1000) begin
      if (!busy) busy_low++;
      n++;
      @(negedge clk);
    end
    check("start_low_len", n, START_LOW_US);
    check("start_busy_held", busy_low, 0);
    check("release_busy", int'(busy), 1);
    if (respond) begin
      repeat (20) @(negedge clk);
      line = 1'b0;
      repeat (80) @(negedge clk);
      line = 1'b1;
      repeat (80) @(negedge clk);
      for (int b = 0; b < 40 && !aborted; b++) begin
        line = 1'b0;
        for (int i = 0; i < 50; i++) begin
          start = (b == restart_bit) && (i == 5);
          @(negedge clk);
        end
        start = 1'b0;
        if (b == restart_bit) begin
          check("restart_dir", int'(dir), 0);
          check("restart_busy", int'(busy), 1);
        end
        line = 1'b1;
        for (int i = 0; i < hi_w[b] && !aborted; i++) begin
          if (b == abort_bit && i == 10) begin
            reset = 1'b1;
            @(negedge clk);
            reset   = 1'b0;
            aborted = 1'b1;
            check("abort_ctrl", int'({dir, busy, done, error}), 0);
            check("abort_data", int'({hum_int, hum_dec, tmp_int, tmp_dec}), 0);
          end else begin
            @(negedge clk);
          end
        end
      end
      if (!aborted) begin
        line     = 1'b0;
        fall_cyc = cyc;
        repeat (50) @(negedge clk);
      end
      line = 1'b1;
      repeat (5) @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0, n;
    reset = 1'b1;
    start = 1'b0;
    line  = 1'b1;
    for (int b = 0; b < 40; b++) hi_w[b] = 26;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("reset_ctrl", int'({dir, data_out, busy, done, error}), 0);
    check("reset_data", int'({hum_int, hum_dec, tmp_int, tmp_dec}), 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // valid frame
    set_widths(40'h37_00_19_00_50);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b1, -1, -1);
    check("s2_done", done_cnt - d0, 1);
    check("s2_error", err_cnt - e0, 0);
    check("s2_hum_int", int'(hum_int), 55);
    check("s2_tmp_int", int'(tmp_int), 25);
    check("s2_busy", int'(busy), 0);
    check("s2_latency", done_cyc - fall_cyc, 4);

    // bad checksum
    set_widths(40'h37_00_19_00_51);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b1, -1, -1);
    check("s3_done", done_cnt - d0, 0);
    check("s3_error", err_cnt - e0, 1);
    check("s3_hum_int", int'(hum_int), 55);
    check("s3_tmp_int", int'(tmp_int), 25);
    check("s3_latency", err_cyc - fall_cyc, 4);

    // widths 26/70/40/41 on the top four bits -> 0,1,0,1
    set_widths(40'h5A_00_14_00_6E);
    hi_w[0] = 26; hi_w[1] = 70; hi_w[2] = 40; hi_w[3] = 41;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b1, -1, -1);
    check("s4_done", done_cnt - d0, 1);
    check("s4_error", err_cnt - e0, 0);
    check("s4_hum_int", int'(hum_int), 90);
    check("s4_tmp_int", int'(tmp_int), 20);

    // no response
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b0, -1, -1);
    n = 0;
    while (!error && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("s5_timeout_us", n, 100);
    check("s5_dir", int'(dir), 0);
    check("s5_busy", int'(busy), 0);
    @(negedge clk);
    check("s5_error", err_cnt - e0, 1);
    check("s5_done", done_cnt - d0, 0);
    check("s5_hum_int", int'(hum_int), 90);

    // reset during bit 17, then a normal frame
    set_widths(40'h37_00_19_00_50);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b1, 17, -1);
    repeat (5) @(negedge clk);
    check("s6_abort_strobes", (done_cnt - d0) + (err_cnt - e0), 0);
    run_frame(1'b1, -1, -1);
    check("s6_done", done_cnt - d0, 1);
    check("s6_hum_int", int'(hum_int), 55);
    check("s6_tmp_int", int'(tmp_int), 25);

    // start pulsed mid-frame is ignored
    set_widths(40'h41_05_1C_02_64);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(1'b1, -1, 10);
    repeat (30) @(negedge clk);
    check("s7_done", done_cnt - d0, 1);
    check("s7_error", err_cnt - e0, 0);
    check("s7_bytes", int'({hum_int, hum_dec, tmp_int, tmp_dec}), 32'h41051C02);
    check("s7_idle_dir", int'(dir), 0);

    check("strobe_overlap", both_cnt, 0);
    check("strobe_width", long_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
